twos_comp_serial_decoder: RTL and testbench

Bit-serial receiver that reconstructs a 12-bit two's-complement word sent LSB-first and outputs its negation (−x mod 2^WIDTH) with a valid/ready handshake. It is the serial counterpart of the parallel negation datapath. It sits between a serial link carrying negated words and the parallel register file that consumes them. It uses the serial negation rule: copy bits up to and including the first 1, then invert every later bit.

---
 rtl/twos_comp_pkg.sv | 13 +
 rtl/serial_negate_cell.sv | 33 +++
 rtl/twos_comp_serial_decoder.sv | 148 ++++++++++++++
 tb/tb_twos_comp_serial_decoder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/twos_comp_pkg.sv
// Shared constants and state encoding for the bit-serial two's-complement negation receiver.
package twos_comp_pkg;

  localparam int WIDTH_DEF = 12;
  localparam int CNT_W     = $clog2(WIDTH_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_negate_cell.sv
// One-bit serial negation: copy bits up to and including the first 1, invert the rest.
module serial_negate_cell (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic restart,
  input  logic bit_in,
  output logic o
);

  logic seen_one_q;
  logic seen_one_d;
  logic seen_eff;

  // A restart bit is bit 0 of a fresh word, so any earlier 1 must be ignored.
  always_comb begin
    seen_eff   = seen_one_q & ~restart;
    o          = seen_eff ? ~bit_in : bit_in;
    seen_one_d = seen_one_q;
    if (en) begin
      seen_one_d = seen_eff | bit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      seen_one_q <= 1'b0;
    end else begin
      seen_one_q <= seen_one_d;
    end
  end

endmodule

// File: rtl/twos_comp_serial_decoder.sv
// Receives a WIDTH-bit word LSB-first and presents its two's-complement negation.
// Handshakes: a serial bit moves when s_valid && s_ready; a result moves when out_valid && out_ready.
module twos_comp_serial_decoder
  import twos_comp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             t_clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_start,
  input  logic             s_bit,
  output logic             s_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_in_neg,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic [WIDTH-1:0] out_word_q, out_word_d;
  logic             out_in_neg_q, out_in_neg_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             s_ready_q, s_ready_d;

  logic accept;
  logic cell_en;
  logic neg_bit;

  assign accept  = s_valid && s_ready_q;
  // Non-start bits seen in IDLE are discarded and must not disturb the cell.
  assign cell_en = accept && (s_start || (state_q == SHIFT));

  serial_negate_cell u_cell (
    .clk     (t_clk),
    .clr     (rst),
    .en      (cell_en),
    .restart (s_start),
    .bit_in  (s_bit),
    .o       (neg_bit)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    raw_d        = raw_q;
    out_word_d   = out_word_q;
    out_in_neg_d = out_in_neg_q;
    out_ovf_d    = out_ovf_q;
    out_valid_d  = out_valid_q;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (s_start) begin
            state_d = SHIFT;
            cnt_d   = CW'(1);
            shreg_d = {neg_bit, {(WIDTH-1){1'b0}}};
            raw_d   = {s_bit, {(WIDTH-1){1'b0}}};
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (accept) begin
          if (s_start) begin
            frame_err_d = 1'b1;
            cnt_d       = CW'(1);
            shreg_d     = {neg_bit, {(WIDTH-1){1'b0}}};
            raw_d       = {s_bit, {(WIDTH-1){1'b0}}};
          end else begin
            shreg_d = {neg_bit, shreg_q[WIDTH-1:1]};
            raw_d   = {s_bit, raw_q[WIDTH-1:1]};
            if (cnt_q == LAST_CNT) begin
              // raw_q[WIDTH-1:1] already holds bits 0..WIDTH-2 of the received word.
              state_d      = HOLD;
              cnt_d        = '0;
              out_word_d   = shreg_d;
              out_in_neg_d = s_bit;
              out_ovf_d    = s_bit && (raw_q[WIDTH-1:1] == '0);
              out_valid_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    s_ready_d = (state_d != HOLD);
  end

  always_ff @(posedge t_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shreg_q      <= '0;
      raw_q        <= '0;
      out_word_q   <= '0;
      out_in_neg_q <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      s_ready_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      raw_q        <= raw_d;
      out_word_q   <= out_word_d;
      out_in_neg_q <= out_in_neg_d;
      out_ovf_q    <= out_ovf_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      s_ready_q    <= s_ready_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign out_word   = out_word_q;
  assign out_in_neg = out_in_neg_q;
  assign out_ovf    = out_ovf_q;
  assign out_valid  = out_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_twos_comp_serial_decoder.sv
// Bench for twos_comp_serial_decoder: directed corner words plus random words with gaps,
// checked against an arithmetic negation model.
module tb_twos_comp_serial_decoder;

  localparam int W = 12;

  logic         t_clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_start = 1'b0;
  logic         s_bit = 1'b0;
  logic         s_ready;
  logic [W-1:0] out_word;
  logic         out_in_neg;
  logic         out_ovf;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         frame_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Packed expectation: {ovf, in_neg, word}
  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_exp;

  twos_comp_serial_decoder #(.WIDTH(W)) dut (
    .t_clk      (t_clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_start    (s_start),
    .s_bit      (s_bit),
    .s_ready    (s_ready),
    .out_word   (out_word),
    .out_in_neg (out_in_neg),
    .out_ovf    (out_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err)
  );

  // Clock
  always #5 t_clk = ~t_clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: negation is plain modular arithmetic on the received value.
  function automatic logic [W+1:0] model(input logic [W-1:0] x);
    int unsigned modv;
    int unsigned neg;
    logic        ovf;
    logic        sign;
    modv = 32'd1 << W;
    neg  = (modv - int'(x)) % modv;
    sign = (int'(x) >= (1 << (W - 1)));
    ovf  = (int'(x) == (1 << (W - 1)));
    return {ovf, sign, neg[W-1:0]};
  endfunction

  task automatic tick();
    @(posedge t_clk);
    #1;
  endtask

  task automatic idle_cycle();
    s_valid = 1'b0;
    s_start = 1'b0;
    tick();
  endtask

  task automatic put_bit(input logic b, input logic st);
    s_valid = 1'b1;
    s_start = st;
    s_bit   = b;
    tick();
    s_valid = 1'b0;
    s_start = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] x, input int gap_pct, input logic ferr_bit0);
    for (int i = 0; i < W; i++) begin
      if (i > 0 && $urandom_range(0, 99) < gap_pct) idle_cycle();
      put_bit(x[i], (i == 0));
      if (i == 0) chk("frame_err_bit0", frame_err, ferr_bit0);
      if (i == 1) chk("frame_err_one_cycle", frame_err, 0);
      if (i == W - 2) chk("valid_early", out_valid, 0);
    end
    chk("valid_latency", out_valid, 1);
    exp_q.push_back(model(x));
  endtask

  task automatic check_out();
    last_exp = exp_q.pop_front();
    chk("out_word", out_word, last_exp[W-1:0]);
    chk("out_in_neg", out_in_neg, last_exp[W]);
    chk("out_ovf", out_ovf, last_exp[W+1]);
  endtask

  task automatic handshake(input int delay);
    for (int c = 0; c < delay; c++) begin
      s_valid = 1'b1;
      s_start = 1'($urandom_range(0, 1));
      s_bit   = 1'($urandom_range(0, 1));
      tick();
      chk("hold_s_ready", s_ready, 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_frame_err", frame_err, 0);
      chk("hold_word", out_word, last_exp[W-1:0]);
    end
    s_valid   = 1'b0;
    s_start   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_valid_drop", out_valid, 0);
    chk("hs_s_ready", s_ready, 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_word"}, out_word, 0);
    chk({tag, "_out_in_neg"}, out_in_neg, 0);
    chk({tag, "_out_ovf"}, out_ovf, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
  endtask

  task automatic word_roundtrip(input logic [W-1:0] x, input int gap_pct, input int delay);
    send_word(x, gap_pct, 1'b0);
    check_out();
    handshake(delay);
  endtask

  initial begin
    logic [W-1:0] x;

    // Reset
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;

    // Directed corner words
    word_roundtrip(12'h005, 0, 0);
    word_roundtrip(12'hFFB, 0, 1);
    word_roundtrip(12'h000, 0, 0);
    word_roundtrip(12'h800, 0, 2);
    word_roundtrip(12'h7FF, 0, 0);

    // Non-start bit in IDLE: error pulse, no state change
    put_bit(1'b1, 1'b0);
    chk("idle_nostart_ferr", frame_err, 1);
    chk("idle_nostart_ready", s_ready, 1);
    chk("idle_nostart_valid", out_valid, 0);
    idle_cycle();
    chk("idle_nostart_ferr_drop", frame_err, 0);
    word_roundtrip(12'h123, 0, 0);

    // Abort mid-word: 5 bits then a restart carrying 12'h001
    x = W'($urandom);
    for (int i = 0; i < 5; i++) put_bit(x[i], (i == 0));
    chk("abort_no_ferr_yet", frame_err, 0);
    send_word(12'h001, 0, 1'b1);
    check_out();
    handshake(0);

    // Long backpressure, then the next word must still decode
    word_roundtrip(W'($urandom), 20, 10);
    word_roundtrip(12'h400, 0, 0);

    // Reset after bit 7 discards the partial word
    x = W'($urandom);
    for (int i = 0; i < 8; i++) put_bit(x[i], (i == 0));
    rst     = 1'b1;
    s_valid = 1'b1;
    s_start = 1'b1;
    s_bit   = 1'b1;
    tick();
    s_valid = 1'b0;
    s_start = 1'b0;
    rst     = 1'b0;
    check_reset_values("rst_mid");
    word_roundtrip(12'h7FF, 0, 0);

    // Reset while a result is pending in HOLD
    send_word(12'hABC, 0, 1'b0);
    check_out();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("rst_hold");
    word_roundtrip(12'h801, 0, 0);

    // Random words with gaps and random consumer delay
    for (int n = 0; n < 40; n++) begin
      word_roundtrip(W'($urandom), 25, $urandom_range(0, 3));
    end

    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
